// File: rtl/exe_stage_if.sv
// ID/EX to EX/MEM signal bundle for the ARM execute stage.
// The master side drives instruction fields; the slave (exe_stage) returns results and status.
interface exe_stage_if;
  logic        flush;
  logic        wb_en;
  logic        mem_r_en;
  logic        mem_w_en;
  logic        b;
  logic        s;
  logic [3:0]  exe_cmd;
  logic [31:0] pc;
  logic [31:0] val_rn;
  logic [31:0] val_rm;
  logic        imm;
  logic [11:0] shift_operand;
  logic [23:0] signed_imm_24;
  logic [3:0]  dest;
  logic [31:0] alu_res;
  logic [31:0] br_addr;
  logic        wb_en_o;
  logic        mem_r_en_o;
  logic        mem_w_en_o;
  logic [3:0]  dest_o;
  logic [31:0] st_val;
  logic [3:0]  status;
  logic        exe_stall;

  modport master (
    output flush, wb_en, mem_r_en, mem_w_en, b, s, exe_cmd, pc, val_rn, val_rm,
           imm, shift_operand, signed_imm_24, dest,
    input  alu_res, br_addr, wb_en_o, mem_r_en_o, mem_w_en_o, dest_o, st_val,
           status, exe_stall
  );

  modport slave (
    input  flush, wb_en, mem_r_en, mem_w_en, b, s, exe_cmd, pc, val_rn, val_rm,
           imm, shift_operand, signed_imm_24, dest,
    output alu_res, br_addr, wb_en_o, mem_r_en_o, mem_w_en_o, dest_o, st_val,
           status, exe_stall
  );
endinterface

// File: rtl/exe_stage.sv
// ARM execute stage: shifter operand (Val2), ALU, branch target and the NZCV register.
// Define EXE_MULTIPLIER_EN to add the iterative MUL unit that stalls the front end.
module exe_stage #(
  parameter int MUL_BITS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  exe_stage_if.slave ex_if
);
  localparam logic [3:0] OP_MOV = 4'b0001;
  localparam logic [3:0] OP_MVN = 4'b1001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_ADC = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_SBC = 4'b0101;
  localparam logic [3:0] OP_AND = 4'b0110;
  localparam logic [3:0] OP_ORR = 4'b0111;
  localparam logic [3:0] OP_EOR = 4'b1000;
`ifdef EXE_MULTIPLIER_EN
  localparam logic [3:0] OP_MUL = 4'b1010;
`endif

  function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] r);
    return (x >> r) | (x << (6'd32 - {1'b0, r}));
  endfunction

  // Shift amount 0 leaves the operand untouched for every shift type.
  function automatic logic [31:0] shifter(input logic        mem,
                                          input logic        imm_f,
                                          input logic [11:0] so,
                                          input logic [31:0] rm);
    logic signed [31:0] rm_s;
    logic        [31:0] r;
    logic        [4:0]  amt;
    rm_s = rm;
    amt  = so[11:7];
    if (mem) begin
      r = {20'b0, so};
    end else if (imm_f) begin
      r = ror32({24'b0, so[7:0]}, {so[11:8], 1'b0});
    end else begin
      case (so[6:5])
        2'b00:   r = rm << amt;
        2'b01:   r = rm >> amt;
        2'b10:   r = rm_s >>> amt;
        default: r = ror32(rm, amt);
      endcase
    end
    return r;
  endfunction

  logic [3:0]  status_q, status_d;
  logic [31:0] val2, alu_res_w, addend;
  logic [32:0] sum;
  logic        cin, arith, op_def, is_sub, ovf, flag_we, exe_stall_w, kill;
  logic        unused_b;

  // b only steers PC selection in IF; EX computes br_addr unconditionally.
  assign unused_b = ex_if.b;

`ifdef EXE_MULTIPLIER_EN
  localparam int         N        = 32 / MUL_BITS;
  localparam logic [5:0] CNT_LOAD = 6'(N);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state_q, state_d;
  logic [5:0]            cnt_q, cnt_d;
  logic [63:0]           acc_q, acc_d;
  logic [31:0]           mcand_q, mcand_d, mplier_q, mplier_d;
  logic [31+MUL_BITS:0]  pp, hi_sum;
  logic                  start, mul_done;

  // Gating with rst_n keeps exe_stall low while reset is held with a MUL in ID/EX.
  assign start    = rst_n && (state_q == IDLE) && (ex_if.exe_cmd == OP_MUL) &&
                    ex_if.wb_en && !ex_if.flush;
  assign mul_done = (state_q == DONE);

  // Right-shifting accumulator: the partial product lands in the upper half and the
  // whole accumulator slides down MUL_BITS per step; after N steps it holds the product.
  assign pp     = {{MUL_BITS{1'b0}}, mcand_q} * {32'b0, mplier_q[MUL_BITS-1:0]};
  assign hi_sum = pp + {{MUL_BITS{1'b0}}, acc_q[63:32]};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    exe_stall_w = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = RUN;
          cnt_d       = CNT_LOAD;
          acc_d       = '0;
          mcand_d     = ex_if.val_rn;
          mplier_d    = ex_if.val_rm;
          exe_stall_w = 1'b1;
        end
      end
      RUN: begin
        if (ex_if.flush) begin
          state_d = IDLE;
        end else begin
          exe_stall_w = 1'b1;
          acc_d       = {hi_sum, acc_q[31:MUL_BITS]};
          mplier_d    = mplier_q >> MUL_BITS;
          cnt_d       = cnt_q - 6'd1;
          if (cnt_q == 6'd1) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Datapath registers carry no reset; the FSM never reads them outside RUN/DONE.
  always_ff @(posedge clk) begin
    acc_q    <= acc_d;
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
  end
`else
  localparam int unused_mul_bits = MUL_BITS;
  assign exe_stall_w = 1'b0;
`endif

  assign val2   = shifter(ex_if.mem_r_en | ex_if.mem_w_en, ex_if.imm,
                          ex_if.shift_operand, ex_if.val_rm);
  assign is_sub = (ex_if.exe_cmd == OP_SUB) || (ex_if.exe_cmd == OP_SBC);
  assign addend = is_sub ? ~val2 : val2;

  // Subtraction is Rn + ~Val2 + cin, so C comes out as "no borrow" directly.
  always_comb begin
    cin = 1'b0;
    case (ex_if.exe_cmd)
      OP_SUB:         cin = 1'b1;
      OP_ADC, OP_SBC: cin = status_q[1];
      default:        cin = 1'b0;
    endcase
  end

  assign sum = {1'b0, ex_if.val_rn} + {1'b0, addend} + {32'b0, cin};
  assign ovf = (ex_if.val_rn[31] == addend[31]) && (sum[31] != ex_if.val_rn[31]);

  always_comb begin
    alu_res_w = '0;
    arith     = 1'b0;
    op_def    = 1'b1;
    case (ex_if.exe_cmd)
      OP_MOV: alu_res_w = val2;
      OP_MVN: alu_res_w = ~val2;
      OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
        alu_res_w = sum[31:0];
        arith     = 1'b1;
      end
      OP_AND: alu_res_w = ex_if.val_rn & val2;
      OP_ORR: alu_res_w = ex_if.val_rn | val2;
      OP_EOR: alu_res_w = ex_if.val_rn ^ val2;
`ifdef EXE_MULTIPLIER_EN
      OP_MUL: begin
        alu_res_w = mul_done ? acc_q[31:0] : 32'd0;
        op_def    = mul_done;
      end
`endif
      default: op_def = 1'b0;
    endcase
  end

  assign kill     = ex_if.flush | exe_stall_w;
  assign flag_we  = ex_if.s && !kill && op_def;
  assign status_d = flag_we ? {alu_res_w[31], (alu_res_w == 32'd0),
                               arith ? sum[32] : status_q[1],
                               arith ? ovf     : status_q[0]}
                            : status_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) status_q <= '0;
    else        status_q <= status_d;
  end

  assign ex_if.alu_res    = alu_res_w;
  assign ex_if.br_addr    = ex_if.pc + {{6{ex_if.signed_imm_24[23]}}, ex_if.signed_imm_24, 2'b00};
  assign ex_if.wb_en_o    = ex_if.wb_en & ~kill;
  assign ex_if.mem_r_en_o = ex_if.mem_r_en & ~kill;
  assign ex_if.mem_w_en_o = ex_if.mem_w_en & ~kill;
  assign ex_if.dest_o     = ex_if.dest;
  assign ex_if.st_val     = ex_if.val_rm;
  assign ex_if.status     = status_q;
  assign ex_if.exe_stall  = exe_stall_w;
endmodule
